// File: rtl/countdown_timer.sv
// Two-digit BCD countdown timer with prescaled tick, pause and blinking done.
// Drives a pair of seven-segment codes for the units and tens digits.
module countdown_timer #(
  parameter int CNT_MAX_FAST = 5_999_999,
  parameter int CNT_MAX_SLOW = 11_999_999
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_units,
  input  logic       start,
  input  logic       hold,
  input  logic       speed,
  output logic [8:0] led_out1,
  output logic [8:0] led_out2,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_t;

  state_t      state, state_nx;
  logic [3:0]  tens, tens_nx;
  logic [3:0]  units, units_nx;
  logic [24:0] cnt, cnt_nx;
  logic        blink, blink_nx;
  logic [24:0] cnt_max;
  logic        wrap;
  logic        blank;
  logic [3:0]  tens_ld;
  logic [3:0]  units_ld;

  function automatic logic [8:0] seg(input logic [3:0] d);
    case (d)
      4'd0:    seg = 9'h03f;
      4'd1:    seg = 9'h006;
      4'd2:    seg = 9'h05b;
      4'd3:    seg = 9'h04f;
      4'd4:    seg = 9'h066;
      4'd5:    seg = 9'h06d;
      4'd6:    seg = 9'h07d;
      4'd7:    seg = 9'h007;
      4'd8:    seg = 9'h07f;
      4'd9:    seg = 9'h06f;
      default: seg = 9'h000;
    endcase
  endfunction

  // >= rather than == so a speed change mid-count still wraps
  assign cnt_max  = speed ? 25'(CNT_MAX_SLOW)
                          : 25'(CNT_MAX_FAST);
  assign wrap     = cnt >= cnt_max;
  assign tens_ld  = (load_tens > 4'd6) ? 4'd6 : load_tens;
  assign units_ld = (load_units > 4'd9) ? 4'd9 : load_units;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tens  <= 4'd0;
      units <= 4'd0;
      cnt   <= 25'd0;
      blink <= 1'b0;
    end else begin
      state <= state_nx;
      tens  <= tens_nx;
      units <= units_nx;
      cnt   <= cnt_nx;
      blink <= blink_nx;
    end
  end

  always_comb begin
    state_nx = state;
    tens_nx  = tens;
    units_nx = units;
    cnt_nx   = cnt;
    blink_nx = blink;
    unique case (state)
      IDLE: begin
        if (load) begin
          tens_nx  = tens_ld;
          units_nx = units_ld;
          cnt_nx   = 25'd0;
          blink_nx = 1'b0;
        end else if (start && (tens != 4'd0 || units != 4'd0)) begin
          state_nx = RUN;
          cnt_nx   = 25'd0;
        end
      end
      RUN: begin
        if (hold) begin
          state_nx = PAUSE;
        end else if (wrap) begin
          cnt_nx = 25'd0;
          if (units != 4'd0) begin
            units_nx = units - 4'd1;
          end else begin
            units_nx = 4'd9;
            tens_nx  = tens - 4'd1;
          end
          if (tens == 4'd0 && units == 4'd1) state_nx = DONE;
        end else begin
          cnt_nx = cnt + 25'd1;
        end
      end
      PAUSE: begin
        if (!hold) state_nx = RUN;
      end
      DONE: begin
        if (load) begin
          state_nx = IDLE;
          tens_nx  = tens_ld;
          units_nx = units_ld;
          cnt_nx   = 25'd0;
          blink_nx = 1'b0;
        end else if (wrap) begin
          cnt_nx   = 25'd0;
          blink_nx = ~blink;
        end else begin
          cnt_nx = cnt + 25'd1;
        end
      end
    endcase
  end

  assign blank    = (state == DONE) && blink;
  assign led_out1 = blank ? 9'h000 : seg(units);
  assign led_out2 = blank ? 9'h000 : seg(tens);
  assign done     = (state == DONE);

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: decimal-value reference model,
// directed scenarios followed by randomized stimulus.
module tb_countdown_timer;

  localparam int FM = 3;
  localparam int SM = 7;

  logic       clk = 1'b0;
  logic       rst, load, start, hold, speed;
  logic [3:0] load_tens, load_units;
  logic [8:0] led_out1, led_out2;
  logic       done;

  countdown_timer #(.CNT_MAX_FAST(FM), .CNT_MAX_SLOW(SM)) dut (
    .clk(clk), .rst(rst), .load(load),
    .load_tens(load_tens), .load_units(load_units),
    .start(start), .hold(hold), .speed(speed),
    .led_out1(led_out1), .led_out2(led_out2), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] l1;
    logic [8:0] l2;
    logic       d;
    int         id;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc_id = 0;

  // model: mode 0 idle, 1 counting, 2 paused, 3 finished
  int m_mode = 0;
  int m_val = 0;
  int m_pc = 0;
  bit m_blink = 0;

  function automatic logic [8:0] seg7(input int d);
    logic [8:0] t [10];
    t = '{9'h03f, 9'h006, 9'h05b, 9'h04f, 9'h066,
          9'h06d, 9'h07d, 9'h007, 9'h07f, 9'h06f};
    return t[d];
  endfunction

  task automatic model_step(input bit r, input bit ld,
                            input int lt, input int lu,
                            input bit st, input bit hd,
                            input bit sp);
    int mx;
    mx = sp ? SM : FM;
    if (r) begin
      m_mode = 0; m_val = 0; m_pc = 0; m_blink = 0;
    end else if (ld && (m_mode == 0 || m_mode == 3)) begin
      m_val = (lt > 6 ? 6 : lt) * 10 + (lu > 9 ? 9 : lu);
      m_mode = 0; m_pc = 0; m_blink = 0;
    end else if (m_mode == 0) begin
      if (st && m_val != 0) begin
        m_mode = 1; m_pc = 0;
      end
    end else if (m_mode == 1) begin
      if (hd) m_mode = 2;
      else if (m_pc >= mx) begin
        m_pc = 0;
        m_val = m_val - 1;
        if (m_val == 0) m_mode = 3;
      end else m_pc++;
    end else if (m_mode == 2) begin
      if (!hd) m_mode = 1;
    end else begin
      if (m_pc >= mx) begin
        m_pc = 0;
        m_blink = ~m_blink;
      end else m_pc++;
    end
  endtask

  task automatic cyc(input bit r, input bit ld, input int lt,
                     input int lu, input bit st, input bit hd,
                     input bit sp);
    exp_t e;
    @(negedge clk);
    rst = r; load = ld; start = st; hold = hd; speed = sp;
    load_tens = 4'(lt); load_units = 4'(lu);
    model_step(r, ld, lt, lu, st, hd, sp);
    e.d = (m_mode == 3);
    if (e.d && m_blink) begin
      e.l1 = 9'h000; e.l2 = 9'h000;
    end else begin
      e.l1 = seg7(m_val % 10);
      e.l2 = seg7(m_val / 10);
    end
    e.id = cyc_id++;
    exp_q.push_back(e);
  endtask

  task automatic idle_n(input int n, input bit hd, input bit sp);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, hd, sp);
  endtask

  // monitor: one expected entry per clock edge driven
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (led_out1 !== e.l1 || led_out2 !== e.l2 || done !== e.d) begin
        errors++;
        $display("FAIL cyc%0d got l1=%h l2=%h done=%b want l1=%h l2=%h done=%b",
                 e.id, led_out1, led_out2, done, e.l1, e.l2, e.d);
      end
    end
  end

  initial begin
    int wait_n;
    bit hd, sp;
    rst = 1; load = 0; start = 0; hold = 0; speed = 0;
    load_tens = 0; load_units = 0;
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 3, 3, 1, 1, 1);
    // 02 countdown to done, then blinking
    cyc(0, 1, 0, 2, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    idle_n(20, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    // 10 -> 09
    cyc(0, 1, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    idle_n(6, 0, 0);
    // pause with prescaler at 2
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 5, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    idle_n(2, 0, 0);
    idle_n(10, 1, 0);
    idle_n(6, 0, 0);
    // clamping and start at 00
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 9, 12, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    idle_n(3, 0, 0);
    // done blink then reload 05
    cyc(0, 1, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    idle_n(14, 0, 0);
    cyc(0, 1, 0, 5, 0, 0, 0);
    idle_n(2, 0, 0);
    // load/start ignored in run, reset mid-run with start
    cyc(0, 0, 0, 0, 1, 0, 0);
    idle_n(2, 0, 0);
    cyc(0, 1, 4, 4, 1, 0, 0);
    idle_n(2, 0, 1);
    cyc(1, 0, 0, 0, 1, 0, 0);
    idle_n(3, 0, 0);
    // randomized
    hd = 0; sp = 0;
    for (int i = 0; i < 4000; i++) begin
      bit r, ld, st;
      r  = ($urandom_range(0, 199) == 0);
      ld = ($urandom_range(0, 29) == 0);
      st = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 9) == 0) hd = ~hd;
      if ($urandom_range(0, 39) == 0) sp = ~sp;
      cyc(r, ld, $urandom_range(0, 15), $urandom_range(0, 15),
          st, hd, sp);
    end
    wait_n = 0;
    while (exp_q.size() > 0 && wait_n < 10) begin
      @(posedge clk);
      wait_n++;
    end
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
